// File: rtl/sn_arb_pkg.sv
// rtl/sn_arb_pkg.sv - shared state type and width defaults for the SN request arbiter
//   arb_state_t    : arbiter FSM encoding (IDLE -> ISSUE -> WAIT_DONE)
//   SN_ADDR_WIDTH  : default worklist address width, matches sn_controller
//   SN_WL_LEN_BITS : default worklist length width, matches sn_controller
package sn_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE      = 2'd0,
    ARB_ISSUE     = 2'd1,
    ARB_WAIT_DONE = 2'd2
  } arb_state_t;

  localparam int SN_ADDR_WIDTH  = 64;
  localparam int SN_WL_LEN_BITS = 32;

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin picker
//   i_req   : pending request vector
//   i_ptr   : index that has highest priority this round
//   o_valid : at least one request pending
//   o_idx   : first pending index scanning i_ptr, i_ptr+1, ... mod N
module rr_picker #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic          o_valid,
  output logic [IW-1:0] o_idx
);

  int            w_pos;
  logic [IW-1:0] w_cand;

  // Scan from the farthest offset down to offset 0 so that the candidate
  // closest to i_ptr is the last one written and therefore wins.
  always_comb begin
    o_valid = 1'b0;
    o_idx   = '0;
    w_pos   = 0;
    w_cand  = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_pos = int'(i_ptr) + k;
      if (w_pos >= N) w_pos = w_pos - N;
      w_cand = IW'(w_pos);
      if (i_req[w_cand]) begin
        o_valid = 1'b1;
        o_idx   = w_cand;
      end
    end
  end

endmodule

// File: rtl/sn_req_arbiter.sv
// rtl/sn_req_arbiter.sv - round-robin sharing of the single sn_controller request slot
//   clk, rst                 : clock, asynchronous active-high reset
//   req_op/req_addr/req_len  : per-requester request (flattened, slice i = requester i)
//   req_clr/req_done         : one-hot accept / completion pulses back to requesters
//   SN_next_op/addr/len      : request towards sn_controller
//   SN_clr_next/SN_req_done  : accept / completion from sn_controller
//   arb_busy, grant_idx      : status: transaction in flight, current/last grant
//   busy_cycles              : saturating count of busy cycles
module sn_req_arbiter
  import sn_arb_pkg::*;
#(
  parameter  int NUM_REQ     = 4,
  parameter  int ADDR_WIDTH  = SN_ADDR_WIDTH,
  parameter  int WL_LEN_BITS = SN_WL_LEN_BITS,
  parameter  int CNT_BITS    = 32,
  localparam int IDX_W       = $clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_op,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_REQ*WL_LEN_BITS-1:0] req_len,
  output logic [NUM_REQ-1:0]             req_clr,
  output logic [NUM_REQ-1:0]             req_done,
  output logic                           SN_next_op,
  output logic [ADDR_WIDTH-1:0]          SN_next_addr,
  output logic [WL_LEN_BITS-1:0]         SN_next_len,
  input  logic                           SN_clr_next,
  input  logic                           SN_req_done,
  output logic                           arb_busy,
  output logic [IDX_W-1:0]               grant_idx,
  output logic [CNT_BITS-1:0]            busy_cycles
);

  arb_state_t             r_state;
  logic [IDX_W-1:0]       r_rr_ptr;
  logic [IDX_W-1:0]       r_grant_idx;
  logic [ADDR_WIDTH-1:0]  r_addr;
  logic [WL_LEN_BITS-1:0] r_len;
  logic [CNT_BITS-1:0]    r_busy_cycles;

  logic [ADDR_WIDTH-1:0]  w_addr_arr [NUM_REQ];
  logic [WL_LEN_BITS-1:0] w_len_arr  [NUM_REQ];
  logic                   w_pick_valid;
  logic [IDX_W-1:0]       w_pick_idx;
  logic                   w_busy;
  logic                   w_accept;
  logic                   w_finish;
  logic [IDX_W-1:0]       w_next_ptr;
  logic [NUM_REQ-1:0]     w_grant_onehot;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign w_addr_arr[gi] = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_len_arr[gi]  = req_len[gi*WL_LEN_BITS +: WL_LEN_BITS];
  end

  rr_picker #(
    .N  (NUM_REQ),
    .IW (IDX_W)
  ) u_rr_picker (
    .i_req   (req_op),
    .i_ptr   (r_rr_ptr),
    .o_valid (w_pick_valid),
    .o_idx   (w_pick_idx)
  );

  assign w_busy   = (r_state != ARB_IDLE);
  assign w_accept = (r_state == ARB_ISSUE) && SN_clr_next;
  // Completion is honoured in WAIT_DONE, or in ISSUE when it arrives together
  // with the accept; a stray done without a prior accept is dropped.
  assign w_finish = SN_req_done && ((r_state == ARB_WAIT_DONE) || w_accept);

  assign w_next_ptr     = (r_grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : r_grant_idx + IDX_W'(1);
  assign w_grant_onehot = NUM_REQ'(1) << r_grant_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ARB_IDLE;
      r_rr_ptr    <= '0;
      r_grant_idx <= '0;
      r_addr      <= '0;
      r_len       <= '0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (w_pick_valid) begin
            r_grant_idx <= w_pick_idx;
            r_addr      <= w_addr_arr[w_pick_idx];
            r_len       <= w_len_arr[w_pick_idx];
            r_state     <= ARB_ISSUE;
          end
        end
        ARB_ISSUE: begin
          if (w_accept) begin
            if (w_finish) begin
              r_rr_ptr <= w_next_ptr;
              r_state  <= ARB_IDLE;
            end else begin
              r_state  <= ARB_WAIT_DONE;
            end
          end
        end
        ARB_WAIT_DONE: begin
          if (w_finish) begin
            r_rr_ptr <= w_next_ptr;
            r_state  <= ARB_IDLE;
          end
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy_cycles <= '0;
    end else if (w_busy && (r_busy_cycles != '1)) begin
      r_busy_cycles <= r_busy_cycles + CNT_BITS'(1);
    end
  end

  assign SN_next_op   = (r_state == ARB_ISSUE);
  assign SN_next_addr = w_busy ? r_addr : '0;
  assign SN_next_len  = w_busy ? r_len  : '0;
  assign req_clr      = w_accept ? w_grant_onehot : '0;
  assign req_done     = w_finish ? w_grant_onehot : '0;
  assign arb_busy     = w_busy;
  assign grant_idx    = r_grant_idx;
  assign busy_cycles  = r_busy_cycles;

endmodule

// File: tb/tb_sn_req_arbiter.sv
// tb/tb_sn_req_arbiter.sv - directed table-driven bench for sn_req_arbiter
module tb_sn_req_arbiter;

  localparam logic [63:0] A0 = 64'h0A00;
  localparam logic [63:0] A1 = 64'h0B00;
  localparam logic [63:0] A2 = 64'h1000;
  localparam logic [63:0] A3 = 64'h0D00;
  localparam logic [31:0] L0 = 32'd5;
  localparam logic [31:0] L1 = 32'd6;
  localparam logic [31:0] L2 = 32'd16;
  localparam logic [31:0] L3 = 32'd8;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_op;
  logic [255:0] req_addr;
  logic [127:0] req_len;
  logic [3:0]   req_clr;
  logic [3:0]   req_done;
  logic         SN_next_op;
  logic [63:0]  SN_next_addr;
  logic [31:0]  SN_next_len;
  logic         SN_clr_next;
  logic         SN_req_done;
  logic         arb_busy;
  logic [1:0]   grant_idx;
  logic [3:0]   busy_cycles;

  int n_cmp = 0;
  int n_bad = 0;

  sn_req_arbiter #(
    .NUM_REQ     (4),
    .ADDR_WIDTH  (64),
    .WL_LEN_BITS (32),
    .CNT_BITS    (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_op       (req_op),
    .req_addr     (req_addr),
    .req_len      (req_len),
    .req_clr      (req_clr),
    .req_done     (req_done),
    .SN_next_op   (SN_next_op),
    .SN_next_addr (SN_next_addr),
    .SN_next_len  (SN_next_len),
    .SN_clr_next  (SN_clr_next),
    .SN_req_done  (SN_req_done),
    .arb_busy     (arb_busy),
    .grant_idx    (grant_idx),
    .busy_cycles  (busy_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    logic        clr;
    logic        done;
    logic        op;
    logic [3:0]  eclr;
    logic [3:0]  edone;
    logic [1:0]  grant;
    logic        busy;
    logic [3:0]  cnt;
    logic [63:0] addr;
    logic [31:0] len;
  } vec_t;

  vec_t vecs [24];

  function automatic vec_t mk(input logic [3:0] req, input logic clr, input logic done,
                              input logic op, input logic [3:0] eclr, input logic [3:0] edone,
                              input logic [1:0] grant, input logic busy, input logic [3:0] cnt,
                              input logic [63:0] addr, input logic [31:0] len);
    vec_t v;
    v.req = req; v.clr = clr; v.done = done; v.op = op; v.eclr = eclr; v.edone = edone;
    v.grant = grant; v.busy = busy; v.cnt = cnt; v.addr = addr; v.len = len;
    return v;
  endfunction

  task automatic chk(input string name, input logic [111:0] act, input logic [111:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [111:0] snap();
    return {SN_next_op, req_clr, req_done, grant_idx, arb_busy, busy_cycles, SN_next_addr, SN_next_len};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] exp_oh;

    // Single request to requester 2, then rr wrap 3 -> 0, clr+done together,
    // stray pulses ignored, busy counter saturating at 4'hF.
    vecs[0]  = mk(4'b0100, 0, 0, 0, 4'b0000, 4'b0000, 2'd0, 0, 4'd0,  64'd0, 32'd0);
    vecs[1]  = mk(4'b0100, 0, 0, 1, 4'b0000, 4'b0000, 2'd2, 1, 4'd0,  A2, L2);
    vecs[2]  = mk(4'b0100, 0, 0, 1, 4'b0000, 4'b0000, 2'd2, 1, 4'd1,  A2, L2);
    vecs[3]  = mk(4'b0100, 1, 0, 1, 4'b0100, 4'b0000, 2'd2, 1, 4'd2,  A2, L2);
    vecs[4]  = mk(4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 2'd2, 1, 4'd3,  A2, L2);
    vecs[5]  = mk(4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 2'd2, 1, 4'd4,  A2, L2);
    vecs[6]  = mk(4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 2'd2, 1, 4'd5,  A2, L2);
    vecs[7]  = mk(4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 2'd2, 1, 4'd6,  A2, L2);
    vecs[8]  = mk(4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 2'd2, 1, 4'd7,  A2, L2);
    vecs[9]  = mk(4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 2'd2, 1, 4'd8,  A2, L2);
    vecs[10] = mk(4'b0000, 0, 1, 0, 4'b0000, 4'b0100, 2'd2, 1, 4'd9,  A2, L2);
    vecs[11] = mk(4'b1001, 0, 0, 0, 4'b0000, 4'b0000, 2'd2, 0, 4'd10, 64'd0, 32'd0);
    vecs[12] = mk(4'b1001, 1, 0, 1, 4'b1000, 4'b0000, 2'd3, 1, 4'd10, A3, L3);
    vecs[13] = mk(4'b0001, 0, 1, 0, 4'b0000, 4'b1000, 2'd3, 1, 4'd11, A3, L3);
    vecs[14] = mk(4'b0001, 0, 0, 0, 4'b0000, 4'b0000, 2'd3, 0, 4'd12, 64'd0, 32'd0);
    vecs[15] = mk(4'b0001, 1, 1, 1, 4'b0001, 4'b0001, 2'd0, 1, 4'd12, A0, L0);
    vecs[16] = mk(4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 2'd0, 0, 4'd13, 64'd0, 32'd0);
    vecs[17] = mk(4'b0000, 1, 1, 0, 4'b0000, 4'b0000, 2'd0, 0, 4'd13, 64'd0, 32'd0);
    vecs[18] = mk(4'b0010, 0, 0, 0, 4'b0000, 4'b0000, 2'd0, 0, 4'd13, 64'd0, 32'd0);
    vecs[19] = mk(4'b0010, 0, 1, 1, 4'b0000, 4'b0000, 2'd1, 1, 4'd13, A1, L1);
    vecs[20] = mk(4'b0010, 1, 0, 1, 4'b0010, 4'b0000, 2'd1, 1, 4'd14, A1, L1);
    vecs[21] = mk(4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 2'd1, 1, 4'd15, A1, L1);
    vecs[22] = mk(4'b0000, 0, 1, 0, 4'b0000, 4'b0010, 2'd1, 1, 4'd15, A1, L1);
    vecs[23] = mk(4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 2'd1, 0, 4'd15, 64'd0, 32'd0);

    rst = 1'b1;
    req_op = '0;
    SN_clr_next = 1'b0;
    SN_req_done = 1'b0;
    req_addr = {A3, A2, A1, A0};
    req_len  = {L3, L2, L1, L0};

    @(negedge clk);
    chk("reset_state", snap(), 112'd0);
    @(posedge clk); #1 rst = 1'b0;

    foreach (vecs[i]) begin
      @(posedge clk); #1;
      req_op = vecs[i].req;
      SN_clr_next = vecs[i].clr;
      SN_req_done = vecs[i].done;
      @(negedge clk);
      chk($sformatf("row%0d", i), snap(),
          {vecs[i].op, vecs[i].eclr, vecs[i].edone, vecs[i].grant, vecs[i].busy,
           vecs[i].cnt, vecs[i].addr, vecs[i].len});
    end

    // All four pending continuously from rr_ptr=0: grants 0,1,2,3,0 back-to-back.
    @(posedge clk); #1 rst = 1'b1; req_op = '0; SN_clr_next = 1'b0; SN_req_done = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    for (int g = 0; g < 5; g++) begin
      exp_oh = 4'(1 << (g % 4));
      @(posedge clk); #1 req_op = 4'hF; SN_clr_next = 1'b0; SN_req_done = 1'b0;
      @(posedge clk); #1 SN_clr_next = 1'b1;
      @(negedge clk);
      chk($sformatf("rr_clr%0d", g), {SN_next_op, req_clr}, {1'b1, exp_oh});
      @(posedge clk); #1 SN_clr_next = 1'b0; SN_req_done = 1'b1;
      @(negedge clk);
      chk($sformatf("rr_done%0d", g), {arb_busy, req_done}, {1'b1, exp_oh});
    end
    @(posedge clk); #1 req_op = '0; SN_req_done = 1'b0;
    @(negedge clk);
    chk("rr_busy_cnt", {arb_busy, busy_cycles}, {1'b0, 4'd10});

    // Reset while waiting for done: everything clears at once, no done pulse,
    // and the next grant starts scanning from index 0 again.
    @(posedge clk); #1 req_op = 4'b0100;
    @(posedge clk); #1 SN_clr_next = 1'b1;
    @(negedge clk);
    chk("rst_pre_clr", {SN_next_op, grant_idx, req_clr}, {1'b1, 2'd2, 4'b0100});
    @(posedge clk); #1 SN_clr_next = 1'b0; req_op = '0;
    @(negedge clk);
    chk("rst_pre_wait", {arb_busy, SN_next_op}, {1'b1, 1'b0});
    @(posedge clk); #1 rst = 1'b1; SN_req_done = 1'b1;
    #1;
    chk("rst_mid_wait", snap(), 112'd0);
    @(posedge clk); #1 rst = 1'b0; SN_req_done = 1'b0; req_op = 4'b1001;
    @(posedge clk); #1 SN_clr_next = 1'b1; SN_req_done = 1'b1;
    @(negedge clk);
    chk("rst_regrant", {SN_next_op, grant_idx, SN_next_addr, req_clr, req_done},
        {1'b1, 2'd0, A0, 4'b0001, 4'b0001});
    @(posedge clk); #1 SN_clr_next = 1'b0; SN_req_done = 1'b0; req_op = '0;

    // Hold ISSUE for 21 cycles: counter reaches 4'hF and stays there.
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0; req_op = 4'b0001;
    for (int k = 1; k <= 21; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (k == 15) chk("sat_k15", {SN_next_op, busy_cycles}, {1'b1, 4'd14});
      if (k == 16) chk("sat_k16", {SN_next_op, busy_cycles}, {1'b1, 4'd15});
      if (k == 21) chk("sat_k21", {SN_next_op, busy_cycles}, {1'b1, 4'hF});
    end
    @(posedge clk); #1 SN_clr_next = 1'b1; SN_req_done = 1'b1; req_op = '0;
    @(negedge clk);
    chk("sat_finish", {req_clr, req_done}, {4'b0001, 4'b0001});
    @(posedge clk); #1 SN_clr_next = 1'b0; SN_req_done = 1'b0;
    @(negedge clk);
    chk("sat_idle", {arb_busy, busy_cycles}, {1'b0, 4'hF});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
